// File: rtl/monitor_bus_pkg.sv
// Shared types, constants and the window-match helper for the monitor bus arbiter.
package monitor_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FIX = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam logic [1:0] RDSRC_ZERO = 2'd0;
    localparam logic [1:0] RDSRC_LIVE = 2'd1;
    localparam logic [1:0] RDSRC_HOLD = 2'd2;

    localparam int DATA_MAX = 32;
    localparam logic [DATA_MAX-1:0] DATA_ONES = '1;

    // Addresses are zero-extended to 32 bits so one helper serves any ADDR_W <= 32.
    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/monitor_bus_decode.sv
// Combinational priority decoder: the lowest-numbered matching window wins.
module monitor_bus_decode
    import monitor_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int N_REGIONS = 6,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0]    address,
    output logic                 hit,
    output logic [2:0]           index,
    output logic [N_REGIONS-1:0] onehot
);

    // Scanning from the top down lets the lowest match overwrite any higher one.
    always_comb begin
        hit    = 1'b0;
        index  = 3'd0;
        onehot = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (region_hit(32'(address),
                           32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                           32'(REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
                hit       = 1'b1;
                index     = 3'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/monitor_bus_arbiter.sv
// Monitor CPU bus arbiter: decode, per-region wait states, ack handshake with timeout,
// CPU stall and bus-error reporting. Handshake: an access is accepted when cpu_req=1 in a cycle where cpu_ready=1.
module monitor_bus_arbiter
    import monitor_bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int N_REGIONS = 6,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
        {16'hA000, 16'h9000, 16'h8000, 16'hE000, 16'h0000, 16'hF000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK =
        {16'hF000, 16'hF000, 16'hF000, 16'hE000, 16'hC000, 16'hF000},
    parameter logic [N_REGIONS*4-1:0] REGION_WAIT = 24'h023100,
    parameter logic [N_REGIONS-1:0]   REGION_HS   = 6'b100000,
    parameter int TIMEOUT = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cpu_address,
    input  logic                          cpu_write,
    input  logic                          cpu_req,
    output logic                          cpu_ready,
    output logic [DATA_W-1:0]             read_data,
    output logic [N_REGIONS-1:0]          wr_strobe,
    output logic [N_REGIONS-1:0]          rd_strobe,
    input  logic [N_REGIONS*DATA_W-1:0]   region_data,
    input  logic [N_REGIONS-1:0]          region_ack,
    output logic                          bus_error,
    output logic [7:0]                    err_count,
    output logic [1:0]                    dbg_state
);

    logic                 dec_hit;
    logic [2:0]           dec_index;
    logic [N_REGIONS-1:0] dec_onehot;

    monitor_bus_decode #(
        .ADDR_W      (ADDR_W),
        .N_REGIONS   (N_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .address (cpu_address),
        .hit     (dec_hit),
        .index   (dec_index),
        .onehot  (dec_onehot)
    );

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [2:0]        sel_q, sel_d;          // region of the access in flight
    logic [2:0]        out_sel_q, out_sel_d;  // region shown by the live read mux
    logic [1:0]        rd_src_q, rd_src_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              ready_q, ready_d;
    logic              bus_error_q, bus_error_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              accept;
    logic [3:0]        dec_wait;
    logic [DATA_W-1:0] live_data;
    logic [DATA_W-1:0] pend_data;

    assign accept    = (state_q == IDLE) && cpu_req;
    assign dec_wait  = REGION_WAIT[int'(dec_index)*4 +: 4];
    assign live_data = region_data[int'(out_sel_q)*DATA_W +: DATA_W];
    assign pend_data = region_data[int'(sel_q)*DATA_W +: DATA_W];

    assign rd_strobe = (accept && !cpu_write) ? dec_onehot : '0;
    assign wr_strobe = (accept &&  cpu_write) ? dec_onehot : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        sel_d       = sel_q;
        out_sel_d   = out_sel_q;
        rd_src_d    = rd_src_q;
        hold_d      = hold_q;
        ready_d     = ready_q;
        bus_error_d = 1'b0;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (!dec_hit) begin
                        rd_src_d = RDSRC_ZERO;
                    end else if (REGION_HS[dec_index]) begin
                        state_d = WAIT_ACK;
                        tcnt_d  = 8'd0;
                        sel_d   = dec_index;
                        ready_d = 1'b0;
                    end else if (dec_wait != 4'd0) begin
                        state_d = WAIT_FIX;
                        cnt_d   = dec_wait;
                        sel_d   = dec_index;
                        ready_d = 1'b0;
                    end else begin
                        rd_src_d  = RDSRC_LIVE;
                        out_sel_d = dec_index;
                    end
                end
            end
            WAIT_FIX: begin
                if (cnt_q == 4'd1) begin
                    hold_d   = pend_data;
                    rd_src_d = RDSRC_HOLD;
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_ACK: begin
                // An ack in the expiry cycle is checked first, so it beats the timeout.
                if (region_ack[sel_q]) begin
                    hold_d   = pend_data;
                    rd_src_d = RDSRC_HOLD;
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                    hold_d      = DATA_ONES[DATA_W-1:0];
                    rd_src_d    = RDSRC_HOLD;
                    state_d     = IDLE;
                    ready_d     = 1'b1;
                    bus_error_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            tcnt_q      <= 8'd0;
            sel_q       <= 3'd0;
            out_sel_q   <= 3'd0;
            rd_src_q    <= RDSRC_ZERO;
            hold_q      <= '0;
            ready_q     <= 1'b1;
            bus_error_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            sel_q       <= sel_d;
            out_sel_q   <= out_sel_d;
            rd_src_q    <= rd_src_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            bus_error_q <= bus_error_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        case (rd_src_q)
            RDSRC_LIVE: read_data = live_data;
            RDSRC_HOLD: read_data = hold_q;
            default:    read_data = '0;
        endcase
    end

    assign cpu_ready = ready_q;
    assign bus_error = bus_error_q;
    assign err_count = err_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_monitor_bus_arbiter.sv
// Randomized bench for monitor_bus_arbiter against a transaction-level address-range model.
module tb_monitor_bus_arbiter;

    localparam int N  = 6;
    localparam int DW = 8;
    localparam int TO = 31;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   cpu_address = '0;
    logic          cpu_write = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_ready;
    logic [DW-1:0] read_data;
    logic [N-1:0]  wr_strobe;
    logic [N-1:0]  rd_strobe;
    logic [N*DW-1:0] region_data = '0;
    logic [N-1:0]  region_ack = '0;
    logic          bus_error;
    logic [7:0]    err_count;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int model_err = 0;
    logic [DW-1:0] exp_q[$];

    // Memory map as plain address ranges, lowest index listed first wins.
    int lo[N]    = '{32'hF000, 32'h0000, 32'hE000, 32'h8000, 32'h9000, 32'hA000};
    int hi[N]    = '{32'hFFFF, 32'h3FFF, 32'hFFFF, 32'h8FFF, 32'h9FFF, 32'hAFFF};
    int waits[N] = '{0, 0, 1, 3, 2, 0};
    bit hs[N]    = '{0, 0, 0, 0, 0, 1};

    monitor_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_write   (cpu_write),
        .cpu_req     (cpu_req),
        .cpu_ready   (cpu_ready),
        .read_data   (read_data),
        .wr_strobe   (wr_strobe),
        .rd_strobe   (rd_strobe),
        .region_data (region_data),
        .region_ack  (region_ack),
        .bus_error   (bus_error),
        .err_count   (err_count),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_region(input int a);
        for (int i = 0; i < N; i++)
            if (a >= lo[i] && a <= hi[i]) return i;
        return -1;
    endfunction

    // Starts at a negedge in an idle cycle; returns at the negedge of the completion cycle.
    task automatic do_access(input logic [15:0] addr, input logic wr, input int ack_at,
                             input bit ack_in_t, input int force_data);
        int r;
        int k;
        int exp_stall;
        bit exp_err;
        bit done;
        logic [N-1:0]  exp_oh;
        logic [DW-1:0] exp_d;
        r = model_region(int'(addr));
        for (int i = 0; i < N; i++) region_data[i*DW +: DW] = 8'($urandom_range(0, 255));
        if (r >= 0 && force_data >= 0) region_data[r*DW +: DW] = 8'(force_data);
        cpu_address = addr;
        cpu_write   = wr;
        cpu_req     = 1'b1;
        region_ack  = '0;
        if (r >= 0 && hs[r] && ack_in_t) region_ack[r] = 1'b1;
        exp_oh = (r >= 0) ? N'(1 << r) : '0;
        exp_err = 1'b0;
        if (r < 0) begin
            exp_d = '0;
            exp_stall = 0;
        end else if (hs[r]) begin
            if (ack_at <= TO) begin
                exp_stall = ack_at;
                exp_d = region_data[r*DW +: DW];
            end else begin
                exp_stall = TO;
                exp_d = 8'hFF;
                exp_err = 1'b1;
                if (model_err < 255) model_err++;
            end
        end else begin
            exp_stall = waits[r];
            exp_d = region_data[r*DW +: DW];
        end
        exp_q.push_back(exp_d);
        #1;
        check_eq("rd_strobe", 32'(rd_strobe), wr ? 32'd0 : 32'(exp_oh));
        check_eq("wr_strobe", 32'(wr_strobe), wr ? 32'(exp_oh) : 32'd0);
        @(posedge clk);
        #1;
        cpu_req    = 1'b0;
        region_ack = '0;
        done = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (cpu_ready) begin
                done = 1'b1;
            end else begin
                check_eq("stall_strobe", 32'({rd_strobe, wr_strobe}), 32'd0);
                region_ack = '0;
                if (r >= 0 && hs[r] && k == ack_at) region_ack[r] = 1'b1;
                cpu_req = 1'($urandom_range(0, 1));
            end
        end
        cpu_req    = 1'b0;
        region_ack = '0;
        if (!done) check_eq("ready_bound", 32'd0, 32'd1);
        check_eq("stall_cycles", 32'(k - 1), 32'(exp_stall));
        check_eq("read_data", 32'(read_data), 32'(exp_q.pop_front()));
        check_eq("bus_error", 32'(bus_error), 32'(exp_err));
        check_eq("err_count", 32'(err_count), 32'(model_err));
    endtask

    initial begin
        int rr;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(cpu_ready), 32'd1);
        check_eq("rst_read_data", 32'(read_data), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_access(16'h0010, 1'b0, 0, 1'b0, 8'hA5);
        do_access(16'h8004, 1'b0, 0, 1'b0, 8'h5C);
        do_access(16'hA000, 1'b0, 6, 1'b0, 8'h3E);
        do_access(16'hA123, 1'b0, 200, 1'b0, -1);
        do_access(16'hA010, 1'b0, TO, 1'b0, -1);
        do_access(16'hA010, 1'b1, 5, 1'b1, -1);
        do_access(16'hF000, 1'b0, 0, 1'b0, -1);
        do_access(16'hE001, 1'b0, 0, 1'b0, -1);
        do_access(16'h4000, 1'b1, 0, 1'b0, -1);
        do_access(16'h9ABC, 1'b1, 0, 1'b0, -1);

        for (int n = 0; n < 150; n++) begin
            rr = int'($urandom_range(0, 3));
            do_access(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), -1);
            if (rr == 0) do_access(16'hA000 | 16'($urandom_range(0, 4095)), 1'b0,
                                   int'($urandom_range(1, 40)), 1'b0, -1);
        end

        for (int n = 0; n < 300; n++) do_access(16'hA555, 1'($urandom_range(0, 1)), 999, 1'b0, -1);
        check_eq("err_saturated", 32'(err_count), 32'd255);

        // Reset in the middle of a 3-wait access.
        cpu_address = 16'h8100;
        cpu_write   = 1'b0;
        cpu_req     = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_reset_stall", 32'(cpu_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("abort_ready", 32'(cpu_ready), 32'd1);
        check_eq("abort_read_data", 32'(read_data), 32'd0);
        check_eq("abort_strobes", 32'({rd_strobe, wr_strobe}), 32'd0);
        check_eq("abort_err_count", 32'(err_count), 32'd0);
        check_eq("abort_state", 32'(dbg_state), 32'd0);
        model_err = 0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_eq("post_reset_strobes", 32'({rd_strobe, wr_strobe}), 32'd0);
            check_eq("post_reset_ready", 32'(cpu_ready), 32'd1);
            check_eq("post_reset_read_data", 32'(read_data), 32'd0);
        end
        do_access(16'h8100, 1'b0, 0, 1'b0, 8'h77);
        do_access(16'hA200, 1'b0, 200, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
